mem_byte_sequencer: RTL



---
 rtl/mem_seq_pkg.sv | 21 ++
 rtl/mem_seq_lane_sel.sv | 48 ++++
 rtl/mem_byte_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg
//   Shared types and constants for the word-to-byte memory sequencer.
//   Used by mem_byte_sequencer (top) and mem_seq_lane_sel (byte lane mux).
//   Optional build macro: MEM_SEQ_BIG_ENDIAN_EN (consumed by mem_seq_lane_sel).
package mem_seq_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Byte counter: selects which of the BYTES_PER_WORD bytes is on the bus.
  typedef logic [$clog2(BYTES_PER_WORD)-1:0] byte_idx_t;

  localparam byte_idx_t LAST_BYTE = byte_idx_t'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/mem_seq_lane_sel.sv
// mem_seq_lane_sel
//   Combinational byte-lane steering between a 32-bit word and the byte bus.
//   Extracts byte idx_i from wr_word_i for stores, and returns rd_word_i with
//   byte idx_i replaced by rd_byte_i for loads.
//   Build macro MEM_SEQ_BIG_ENDIAN_EN: when defined, byte k maps to
//   word[31-8k:24-8k]; otherwise byte k maps to word[8k+7:8k].
//
// Ports:
//   wr_word_i  in   DATA_W  latched store word
//   idx_i      in   2       byte counter
//   rd_word_i  in   DATA_W  partially assembled load word
//   rd_byte_i  in   8       byte returned by memory
//   wr_byte_o  out  8       byte to drive onto the memory write bus
//   rd_word_o  out  DATA_W  rd_word_i with the addressed lane updated
module mem_seq_lane_sel
  import mem_seq_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] wr_word_i,
  input  byte_idx_t         idx_i,
  input  logic [DATA_W-1:0] rd_word_i,
  input  logic [BYTE_W-1:0] rd_byte_i,
  output logic [BYTE_W-1:0] wr_byte_o,
  output logic [DATA_W-1:0] rd_word_o
);

  byte_idx_t lane;

`ifdef MEM_SEQ_BIG_ENDIAN_EN
  assign lane = LAST_BYTE - idx_i;
`else
  assign lane = idx_i;
`endif

  // Constant-indexed loop keeps every part-select static.
  always_comb begin
    wr_byte_o = '0;
    rd_word_o = rd_word_i;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (lane == byte_idx_t'(i)) begin
        wr_byte_o                     = wr_word_i[i*BYTE_W +: BYTE_W];
        rd_word_o[i*BYTE_W +: BYTE_W] = rd_byte_i;
      end
    end
  end

endmodule

// File: rtl/mem_byte_sequencer.sv
// mem_byte_sequencer
//   Bridges the MEM pipeline stage to a byte-wide, single-port data memory.
//   Each 32-bit load/store becomes four sequential byte accesses; the
//   pipeline is held with freeze until the sequence completes.
//   Build macro MEM_SEQ_BIG_ENDIAN_EN selects big-endian byte order
//   (see mem_seq_lane_sel); timing is identical in both builds.
//
// Ports:
//   clk            in   1       system clock
//   rst            in   1       synchronous active-high reset
//   mem_r_en       in   1       load request (held while freeze=1)
//   mem_w_en       in   1       store request (held while freeze=1)
//   address        in   ADDR_W  word byte address, bits [1:0] ignored
//   write_data     in   DATA_W  store data
//   freeze         out  1       pipeline stall
//   read_data      out  DATA_W  last assembled load word
//   read_valid     out  1       one-cycle pulse when read_data updated
//   mb_address     out  ADDR_W  byte address to memory
//   mb_write_data  out  8       byte to write
//   mb_r_en        out  1       byte read enable
//   mb_w_en        out  1       byte write enable
//   mb_data        in   8       byte read data (combinational from mb_address)
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting; a request freezes the pipe and latches the operands
// ST_ACCESS | one byte per cycle, k = 0..3, freeze held high
// ST_DONE   | freeze released; loads pulse read_valid; requests ignored
module mem_byte_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_en,
  input  logic              mem_w_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic              freeze,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic [ADDR_W-1:0] mb_address,
  output logic [BYTE_W-1:0] mb_write_data,
  output logic              mb_r_en,
  output logic              mb_w_en,
  input  logic [BYTE_W-1:0] mb_data
);

  state_e            state_q, state_d;
  byte_idx_t         k_q, k_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_op_q, wr_op_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;

  logic [BYTE_W-1:0] lane_wr_byte;
  logic [DATA_W-1:0] rbuf_ins;
  logic              req;

  assign req = mem_r_en | mem_w_en;

  mem_seq_lane_sel #(
    .DATA_W (DATA_W)
  ) u_lane_sel (
    .wr_word_i (wdata_q),
    .idx_i     (k_q),
    .rd_word_i (rbuf_q),
    .rd_byte_i (mb_data),
    .wr_byte_o (lane_wr_byte),
    .rd_word_o (rbuf_ins)
  );

  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    base_d        = base_q;
    wdata_d       = wdata_q;
    wr_op_d       = wr_op_q;
    rbuf_d        = rbuf_q;
    read_data_d   = read_data_q;
    freeze        = 1'b0;
    read_valid    = 1'b0;
    mb_address    = '0;
    mb_write_data = '0;
    mb_r_en       = 1'b0;
    mb_w_en       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          freeze  = 1'b1;
          state_d = ST_ACCESS;
          k_d     = '0;
          base_d  = {address[ADDR_W-1:2], 2'b00};
          wdata_d = write_data;
          // Both enables high resolves to a store.
          wr_op_d = mem_w_en;
        end
      end

      ST_ACCESS: begin
        freeze     = 1'b1;
        mb_address = base_q + ADDR_W'(k_q);
        if (wr_op_q) begin
          mb_w_en       = 1'b1;
          mb_write_data = lane_wr_byte;
        end else begin
          mb_r_en = 1'b1;
          rbuf_d  = rbuf_ins;
          // Publish on the last byte so read_data is already valid in DONE;
          // an aborted load therefore never disturbs read_data.
          if (k_q == LAST_BYTE) begin
            read_data_d = rbuf_ins;
          end
        end
        k_d = k_q + 1'b1;
        if (k_q == LAST_BYTE) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        read_valid = ~wr_op_q;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Quiesce the memory bus in the reset cycle itself so that a reset
    // landing mid-store does not commit the byte currently on the bus.
    if (rst) begin
      freeze        = 1'b0;
      read_valid    = 1'b0;
      mb_address    = '0;
      mb_write_data = '0;
      mb_r_en       = 1'b0;
      mb_w_en       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      base_q      <= '0;
      wdata_q     <= '0;
      wr_op_q     <= 1'b0;
      rbuf_q      <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      wr_op_q     <= wr_op_d;
      rbuf_q      <= rbuf_d;
      read_data_q <= read_data_d;
    end
  end

  assign read_data = read_data_q;

endmodule
